reg_bank_sb: RTL and testbench

REG_BANK_SB -- requirements
Module: reg_bank_sb

---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/reg_bank_sb_pend_counter.sv | 28 ++
 rtl/reg_bank_sb.sv | 88 ++++++++
 tb/tb_reg_bank_sb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared widths and counter limits for the scoreboarded register bank
package reg_bank_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 2;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX_DEF = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/reg_bank_sb_pend_counter.sv
// rtl/reg_bank_sb_pend_counter.sv - saturating pending-write counter, holds on simultaneous inc/dec
import reg_bank_pkg::*;

module pend_counter #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  // A lone retire against an empty counter is reported, never wrapped.
  assign underflow = dec & ~inc & (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !dec && count != '1) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_bank_sb.sv
// rtl/reg_bank_sb.sv - register bank with per-register pending-write scoreboard
// Optional write-to-read forwarding: REG_BANK_SB_BYPASS_EN
import reg_bank_pkg::*;

module reg_bank_sb #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_use,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_dst,
  output logic                     iss_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     sb_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  cnt  [DEPTH];
  logic [DEPTH-1:0]  uflow;
  logic              retire;
  logic              issue;

  assign retire = wr_en && (wr_addr != '0);
  // A same-cycle retire frees the slot, so a full counter can still accept.
  assign iss_ready = (iss_dst == '0) || (cnt[iss_dst] != CNT_MAX) ||
                     (retire && (wr_addr == iss_dst));
  assign issue = iss_valid && iss_ready && (iss_dst != '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_cnt
    pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue && (iss_dst == ADDR_W'(g))),
      .dec       (retire && (wr_addr == ADDR_W'(g))),
      .count     (cnt[g]),
      .underflow (uflow[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (retire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        sb_err <= 1'b0;
    else if (|uflow) sb_err <= 1'b1;
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = rd_addr[p*ADDR_W +: ADDR_W];
      if (rst && ra != '0) begin
        rd_data[p*DATA_W +: DATA_W] = regs[ra];
        rd_busy[p] = (cnt[ra] != '0);
`ifdef REG_BANK_SB_BYPASS_EN
        if (retire && wr_addr == ra) begin
          rd_data[p*DATA_W +: DATA_W] = wr_data;
          if (cnt[ra] == CNT_W'(1)) rd_busy[p] = 1'b0;
        end
`endif
      end
    end
  end

  assign stall = |(rd_use & rd_busy);

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb/tb_reg_bank_sb.sv - scoreboard-driven self-checking bench for reg_bank_sb
module tb_reg_bank_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  rd_use = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        stall;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_dst = '0;
  logic        iss_ready;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        sb_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_bank_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall), .iss_valid(iss_valid), .iss_dst(iss_dst),
    .iss_ready(iss_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_err(sb_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; wr_en = 1'b0; rd_use = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1111; step();
    wr_addr = 5'd2; wr_data = 32'h2222; step();
    wr_en = 1'b0; rd_addr = {5'd2, 5'd1};
    exp_q.push_back('{"pre_rst_p0", 0, 32'h1111, 1'b0});
    exp_q.push_back('{"pre_rst_p1", 1, 32'h2222, 1'b0});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (sb_err !== 1'b1) begin failures++; $display("FAIL pre_rst_sb_err got=%b exp=1", sb_err); end
    #2 rst = 1'b0; iss_valid = 1'b1; iss_dst = 5'd1; rd_use = 2'b11;
    #1;
    exp_q.push_back('{"in_rst_p0", 0, 32'h0, 1'b0});
    exp_q.push_back('{"in_rst_p1", 1, 32'h0, 1'b0});
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (sb_err !== 1'b0 || iss_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL in_rst_ctrl sb_err=%b iss_ready=%b stall=%b expected 0 1 0", sb_err, iss_ready, stall);
    end
    step();
    rst = 1'b1; idle();
    step();
  endtask

  task automatic test_reservation();
    iss_valid = 1'b1; iss_dst = 5'd10;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1) begin failures++; $display("FAIL resv_issue iss_ready=%b exp=1", iss_ready); end
    step();
    iss_valid = 1'b0; rd_addr = {5'd0, 5'd10}; rd_use = 2'b01;
    exp_q.push_back('{"resv_busy", 0, 32'h0, 1'b1});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL resv_stall stall=%b exp=1", stall); end
    step();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd12;
    step();
    wr_en = 1'b0;
    exp_q.push_back('{"resv_after_wb", 0, 32'd12, 1'b0});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (stall !== 1'b0 || sb_err !== 1'b0) begin
      failures++; $display("FAIL resv_clear stall=%b sb_err=%b expected 0 0", stall, sb_err);
    end
    step(); idle();
  endtask

  task automatic test_saturation();
    iss_valid = 1'b1; iss_dst = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_issue%0d iss_ready=%b exp=1", i, iss_ready); end
      step();
    end
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_full iss_ready=%b exp=0", iss_ready); end
    #1 wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_retire_ready iss_ready=%b exp=1", iss_ready); end
    step();
    wr_en = 1'b0; rd_addr = {5'd0, 5'd5}; rd_use = 2'b01;
    exp_q.push_back('{"sat_hold", 0, 32'h55, 1'b1});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_count_stays3 iss_ready=%b exp=0", iss_ready); end
    iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h60 + i;
    end
    step(); wr_en = 1'b0;
    exp_q.push_back('{"sat_drained", 0, 32'h62, 1'b0});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (sb_err !== 1'b0) begin failures++; $display("FAIL sat_no_err sb_err=%b exp=0", sb_err); end
    step(); idle();
  endtask

  task automatic test_bypass();
    iss_valid = 1'b1; iss_dst = 5'd11; step();
    iss_valid = 1'b0; wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h3; step();
    wr_en = 1'b0; iss_valid = 1'b1; step();
    iss_valid = 1'b0;
    rd_addr = {5'd11, 5'd10}; rd_use = 2'b10;
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h7;
    exp_q.push_back('{"byp_other_port", 0, 32'd12, 1'b0});
`ifdef REG_BANK_SB_BYPASS_EN
    exp_q.push_back('{"byp_fwd", 1, 32'h7, 1'b0});
`else
    exp_q.push_back('{"byp_fwd", 1, 32'h3, 1'b1});
`endif
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    step(); wr_en = 1'b0;
    exp_q.push_back('{"byp_next", 1, 32'h7, 1'b0});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    step(); idle();
  endtask

  task automatic test_r0();
    iss_valid = 1'b1; iss_dst = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF;
    rd_addr = {5'd0, 5'd0}; rd_use = 2'b11;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1 || stall !== 1'b0) begin
      failures++; $display("FAIL r0_ctrl iss_ready=%b stall=%b expected 1 0", iss_ready, stall);
    end
    step(); idle(); rd_use = 2'b11;
    exp_q.push_back('{"r0_p0", 0, 32'h0, 1'b0});
    exp_q.push_back('{"r0_p1", 1, 32'h0, 1'b0});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (sb_err !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL r0_after sb_err=%b stall=%b expected 0 0", sb_err, stall);
    end
    step(); idle();
  endtask

  task automatic test_err();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hABC; step();
    wr_en = 1'b0; rd_addr = {5'd0, 5'd3}; rd_use = 2'b01;
    exp_q.push_back('{"err_data", 0, 32'hABC, 1'b0});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (sb_err !== 1'b1) begin failures++; $display("FAIL err_set sb_err=%b exp=1", sb_err); end
    repeat (3) step();
    checks++;
    if (sb_err !== 1'b1) begin failures++; $display("FAIL err_sticky sb_err=%b exp=1", sb_err); end
    iss_valid = 1'b1; iss_dst = 5'd3; step();
    iss_valid = 1'b0;
    // Reset while r3 is reserved must drop the reservation and the error.
    #2 rst = 1'b0; iss_valid = 1'b1; iss_dst = 5'd3;
    #1;
    exp_q.push_back('{"err_rst_p0", 0, 32'h0, 1'b0});
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    checks++;
    if (sb_err !== 1'b0 || iss_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL err_rst_ctrl sb_err=%b iss_ready=%b stall=%b expected 0 1 0", sb_err, iss_ready, stall);
    end
    step(); rst = 1'b1; idle(); rd_use = 2'b01;
    exp_q.push_back('{"err_post_rst", 0, 32'h0, 1'b0});
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
        failures++;
        $display("FAIL %s data=%h busy=%b expected data=%h busy=%b", e.name,
                 rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
      end
    end
    step(); idle();
  endtask

  initial begin
    test_reset();
    test_reservation();
    test_saturation();
    test_bypass();
    test_r0();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
